// File: rtl/div.sv
// 32-bit restoring divider for the EX stage: one quotient bit per cycle, with a
// single-cycle fast path for a zero divisor and an abort when EX drops its request.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_start,
    input  logic        div_signed,
    input  logic [31:0] div_data1,
    input  logic [31:0] div_data2,
    output logic        div_done,
    output logic [63:0] div_result
);

    // state | meaning
    // IDLE  | waiting for div_start; latches operands on acceptance
    // BUSY  | one shift-subtract step per cycle, counter 0..31
    // DONE  | div_done high for one cycle, div_start ignored
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] dvsr;
    logic        sgn_q;
    logic        s1_q;
    logic        s2_q;

    logic [31:0] mag1;
    logic [31:0] mag2;
    logic [33:0] shifted;
    logic [33:0] diff;
    logic [32:0] rem_nxt;
    logic [31:0] quo_nxt;
    logic        q_neg;
    logic        r_neg;
    logic [31:0] q_fin;
    logic [31:0] r_fin;

    always_comb begin
        mag1    = (div_signed && div_data1[31]) ? (~div_data1 + 32'd1) : div_data1;
        mag2    = (div_signed && div_data2[31]) ? (~div_data2 + 32'd1) : div_data2;
        shifted = {rem, quo[31]};
        diff    = shifted - {2'b00, dvsr};
        if (!diff[33]) begin
            rem_nxt = diff[32:0];
            quo_nxt = {quo[30:0], 1'b1};
        end else begin
            rem_nxt = shifted[32:0];
            quo_nxt = {quo[30:0], 1'b0};
        end
        // 0x80000000 / -1 wraps naturally: magnitude quotient 0x80000000, no negation
        q_neg = sgn_q & (s1_q ^ s2_q);
        r_neg = sgn_q & s1_q;
        q_fin = q_neg ? (~quo_nxt + 32'd1) : quo_nxt;
        r_fin = r_neg ? (~rem_nxt[31:0] + 32'd1) : rem_nxt[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            rem        <= 33'd0;
            quo        <= 32'd0;
            dvsr       <= 32'd0;
            sgn_q      <= 1'b0;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            div_done   <= 1'b0;
            div_result <= 64'h0;
        end else begin
            case (state)
                IDLE: begin
                    div_done <= 1'b0;
                    if (div_start) begin
                        sgn_q <= div_signed;
                        s1_q  <= div_data1[31];
                        s2_q  <= div_data2[31];
                        quo   <= mag1;
                        dvsr  <= mag2;
                        rem   <= 33'd0;
                        cnt   <= 5'd0;
                        if (div_data2 == 32'd0) begin
                            div_result <= {div_data1, 32'hFFFF_FFFF};
                            div_done   <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (!div_start) begin
                        state <= IDLE;
                    end else begin
                        rem <= rem_nxt;
                        quo <= quo_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            div_result <= {r_fin, q_fin};
                            div_done   <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                DONE: begin
                    div_done <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    div_done <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; asynchronous and active-high.
REQ-004 Port: slave  ex_div interface (divider end)  -  responder side of the EX-stage divide handshake; carries REQ-005..REQ-010.
REQ-005 Signal: div_start  input  1  request; EX holds it high every cycle until it sees div_done.
REQ-006 Signal: div_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu).
REQ-007 Signal: div_data1  input  32  dividend.
REQ-008 Signal: div_data2  input  32  divisor.
REQ-009 Signal: div_done  output  1  result-valid pulse.
REQ-010 Signal: div_result  output  64  [31:0] = quotient, [63:32] = remainder.

Function
REQ-011 FSM states SHALL be IDLE, BUSY and DONE.
REQ-012 IDLE with div_start=1 SHALL accept the request: latch div_data1, div_data2 and div_signed, and clear the iteration counter.
REQ-013 On acceptance with divisor 0, the FSM SHALL go IDLE->DONE; otherwise it SHALL go IDLE->BUSY.
REQ-014 Latched operands SHALL be used for the whole operation; input changes after acceptance SHALL be ignored.
REQ-015 Signed mode SHALL take operand magnitudes at acceptance and record quotient sign (data1[31]^data2[31]) and remainder sign (data1[31]).
REQ-016 BUSY SHALL perform one restoring shift-subtract step per cycle: 33-bit partial remainder, 32 steps, counter 0..31.
REQ-017 After step 31, BUSY SHALL go to DONE on the next edge with the sign-corrected result registered.
REQ-018 Latency: start accepted at edge T (sampled in IDLE) -> div_done high in cycle T+33 (32 BUSY cycles + 1 DONE cycle).
REQ-019 DONE SHALL assert div_done=1 for exactly one cycle, then return to IDLE unconditionally.
REQ-020 div_start sampled in DONE SHALL be ignored, so EX's deassertion after done causes no re-trigger.
REQ-021 A new request SHALL be accepted no earlier than the IDLE cycle after DONE.
REQ-022 Quotient SHALL truncate toward zero; remainder SHALL take the sign of the dividend; invariant dividend = q*divisor + r.
REQ-023 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give q=0x80000000, r=0, with normal latency.
REQ-024 Divisor 0 (either mode) SHALL give q=0xFFFFFFFF, r=dividend, with div_done in cycle T+1.
REQ-025 Abort: div_start=0 observed in BUSY (EX flushed) SHALL return the FSM to IDLE next edge, with no div_done and div_result unchanged.
REQ-026 A start sampled in the same cycle as an abort SHALL NOT be accepted; acceptance happens only from IDLE.
REQ-027 div_result SHALL be registered and hold its value from DONE until the next completed operation updates it.
REQ-028 div_done SHALL be low in IDLE and BUSY.

Reset
REQ-029 rst=1 SHALL immediately, without waiting for clk, force: state=IDLE, div_done=0, div_result=64'h0, counter=0, latched operands=0.
REQ-030 rst asserted mid-BUSY SHALL discard the operation; after release, the block SHALL accept a new start only on a clk edge with rst=0.

Verification
REQ-031 Unsigned: start, signed=0, 100/7 -> div_done only in cycle T+33, result={32'd2, 32'd14}; done low the following cycle.
REQ-032 Signed: -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; 7/-2 -> q=0xFFFFFFFD, r=1; 0x80000000/-1 -> q=0x80000000, r=0.
REQ-033 Divide by zero: 0x12345678/0, both modes -> div_done at T+1, q=0xFFFFFFFF, r=0x12345678.
REQ-034 Handshake: hold start high through done, drop it the cycle after done, then start a new op two cycles later -> exactly one done pulse per op, second result correct.
REQ-035 Abort/reset: drop start at BUSY step 10 -> no done, result keeps the prior value; separately, pulse rst mid-BUSY between clk edges -> outputs zero immediately, next op correct.
REQ-036 Random: at least 10k random operand/mode pairs checked against a reference model per REQ-022..REQ-024, with operands changed randomly during BUSY having no effect.
